scan_bist_ctrl: RTL and testbench

Parametrised scan-based logic-BIST controller for our ISCAS'89 benchmark circuits. It sits between a scan-inserted benchmark core (s27 by default) and the top level. It generates pseudo-random scan-load and primary-input patterns from an LFSR and sequences shift and capture cycles through a single scan chain. Responses (scan-out plus primary outputs) are compacted into a MISR, and the final signature is compared against a golden value.

---
 rtl/scan_bist_ctrl.sv | 134 +++++++++++++
 tb/tb_scan_bist_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_bist_ctrl.sv
// Scan-based logic-BIST controller: LFSR-driven scan loads and primary inputs,
// MISR compaction of scan-out and primary outputs, golden-signature compare.
module scan_bist_ctrl #(
  parameter int          CHAIN_LEN    = 3,
  parameter int          PI_W         = 4,
  parameter int          PO_W         = 1,
  parameter int          NUM_PATTERNS = 16,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic            CK,
  input  logic            RST,
  input  logic            start,
  output logic            SE,
  output logic            SI,
  input  logic            SO,
  output logic [PI_W-1:0] PI,
  input  logic [PO_W-1:0] PO,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     signature,
  output logic [1:0]      dbg_state
);

  // Handshake: start is a level request honoured only in IDLE or DONE; there is
  // no ready/backpressure, the core takes one shift or capture every cycle.

  localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [15:0]      NUM_PAT    = 16'(NUM_PATTERNS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHIFT   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [15:0]      misr;
  logic [CNT_W-1:0] shift_cnt;
  logic [15:0]      pat_cnt;

  logic [15:0] lfsr_n;
  logic [15:0] misr_so;
  logic [15:0] misr_po;

  // Polynomial x^16+x^14+x^13+x^11+1, shared by the LFSR and the MISR.
  function automatic logic fb_of(input logic [15:0] v);
    return v[15] ^ v[13] ^ v[12] ^ v[10];
  endfunction

  assign lfsr_n  = {lfsr[14:0], fb_of(lfsr)};
  assign misr_so = {misr[14:0], fb_of(misr)} ^ {15'b0, SO};
  assign misr_po = {misr[14:0], fb_of(misr)} ^ 16'(PO);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      lfsr      <= SEED;
      misr      <= '0;
      shift_cnt <= '0;
      pat_cnt   <= '0;
      SE        <= 1'b0;
      SI        <= 1'b0;
      PI        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_SHIFT;
            lfsr      <= SEED;
            misr      <= '0;
            shift_cnt <= '0;
            pat_cnt   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            SE        <= 1'b1;
            SI        <= SEED[0];
          end
        end

        S_SHIFT: begin
          lfsr <= lfsr_n;
          // The first load unloads unknown reset contents, so it is not compacted.
          if (pat_cnt != '0) begin
            misr <= misr_so;
          end
          if (shift_cnt == LAST_SHIFT) begin
            shift_cnt <= '0;
            SE        <= 1'b0;
            SI        <= 1'b0;
            if (pat_cnt == NUM_PAT) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_CAPTURE;
              PI    <= lfsr_n[PI_W-1:0];
            end
          end else begin
            shift_cnt <= shift_cnt + CNT_W'(1);
            SI        <= lfsr_n[0];
          end
        end

        S_CAPTURE: begin
          lfsr      <= lfsr_n;
          misr      <= misr_po;
          pat_cnt   <= pat_cnt + 16'd1;
          shift_cnt <= '0;
          state     <= S_SHIFT;
          SE        <= 1'b1;
          SI        <= lfsr_n[0];
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          SE    <= 1'b0;
        end
      endcase
    end
  end

  assign signature = misr;
  assign pass      = done && (misr == GOLDEN_SIG);
  assign dbg_state = state;

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Bench for scan_bist_ctrl: cycle-indexed reference model of the LFSR/MISR
// schedule driving a loopback scan core or random responses.
module tb_scan_bist_ctrl;

  localparam int          L      = 3;
  localparam int          N      = 16;
  localparam int          BUSY   = (N + 1) * L + N;
  localparam logic [15:0] SEED_V = 16'hACE1;

  function automatic logic [15:0] m_lfsr(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] m_misr(input logic [15:0] v, input logic [15:0] d);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]} ^ d;
  endfunction

  // Signature of a full run against a 3-flop loopback chain with PO tied low.
  function automatic logic [15:0] loop_sig();
    logic [15:0] l;
    logic [15:0] m;
    logic [2:0]  ch;
    l  = SEED_V;
    m  = '0;
    ch = '0;
    for (int k = 0; k < BUSY; k++) begin
      if (k % (L + 1) == L) begin
        m = m_misr(m, 16'h0000);
      end else begin
        if (k / (L + 1) > 0) m = m_misr(m, {15'b0, ch[2]});
        ch = {ch[1:0], l[0]};
      end
      l = m_lfsr(l);
    end
    return m;
  endfunction

  localparam logic [15:0] GOLD_LOOP = loop_sig();

  logic CK  = 1'b0;
  logic RST = 1'b0;
  always #5 CK = ~CK;

  logic        start_a = 1'b0, so_a = 1'b0;
  logic [0:0]  po_a = '0;
  logic        se_a, si_a, busy_a, done_a, pass_a;
  logic [3:0]  pi_a;
  logic [15:0] sig_a;
  logic [1:0]  dbg_a;

  logic        se_b, si_b, busy_b, done_b, pass_b;
  logic [3:0]  pi_b;
  logic [15:0] sig_b;
  logic [1:0]  dbg_b;

  logic        start_c = 1'b0, so_c = 1'b0;
  logic [0:0]  po_c = '0;
  logic        se_c, si_c, busy_c, done_c, pass_c;
  logic [3:0]  pi_c;
  logic [15:0] sig_c;
  logic [1:0]  dbg_c;

  int checks = 0;
  int errors = 0;

  scan_bist_ctrl #(.GOLDEN_SIG(16'h0000)) dut_a (
    .CK(CK), .RST(RST), .start(start_a), .SE(se_a), .SI(si_a), .SO(so_a),
    .PI(pi_a), .PO(po_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a), .dbg_state(dbg_a)
  );

  scan_bist_ctrl #(.GOLDEN_SIG(GOLD_LOOP)) dut_b (
    .CK(CK), .RST(RST), .start(start_a), .SE(se_b), .SI(si_b), .SO(so_a),
    .PI(pi_b), .PO(po_a), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b), .dbg_state(dbg_b)
  );

  scan_bist_ctrl #(.CHAIN_LEN(1), .NUM_PATTERNS(1)) dut_c (
    .CK(CK), .RST(RST), .start(start_c), .SE(se_c), .SI(si_c), .SO(so_c),
    .PI(pi_c), .PO(po_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .signature(sig_c), .dbg_state(dbg_c)
  );

  // mode 0: loopback core, PO=0; mode 1: random SO/PO and random start noise.
  // flip_load inverts the first SO bit of that load; abort_k resets at cycle abort_k.
  task automatic run_a(input int mode, input int flip_load, input int abort_k, input bit hold_start);
    logic [15:0] l;
    logic [15:0] m;
    logic [2:0]  ch;
    logic        so_v;
    logic [0:0]  po_v;
    int          p;
    bit          cap;
    l  = SEED_V;
    m  = '0;
    ch = 3'($urandom);
    start_a = 1'b1;
    @(posedge CK); @(negedge CK);
    for (int k = 0; k < BUSY; k++) begin
      p   = k / (L + 1);
      cap = (k % (L + 1) == L);
      if (!hold_start) start_a = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == abort_k) begin
        start_a = 1'b0;
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({se_a, si_a, pi_a, busy_a, done_a, pass_a, sig_a} !== '0) begin
          errors++;
          $display("FAIL async_reset_mid_run: got se=%b si=%b pi=%h busy=%b done=%b pass=%b sig=%h exp all 0",
                   se_a, si_a, pi_a, busy_a, done_a, pass_a, sig_a);
        end
        @(negedge CK);
        RST = 1'b0;
        return;
      end
      checks++;
      if ({busy_a, done_a, se_a} !== {1'b1, 1'b0, !cap}) begin
        errors++;
        $display("FAIL run_ctrl k=%0d: got busy/done/se=%b%b%b exp 10%b", k, busy_a, done_a, se_a, !cap);
      end
      checks++;
      if (sig_a !== m) begin
        errors++;
        $display("FAIL run_signature k=%0d: got %h exp %h", k, sig_a, m);
      end
      if (!cap) begin
        checks++;
        if (si_a !== l[0]) begin
          errors++;
          $display("FAIL si_stream k=%0d: got %b exp %b", k, si_a, l[0]);
        end
        so_v = (mode == 0) ? ch[2] : 1'($urandom);
        if (p == flip_load && k % (L + 1) == 0) so_v = ~so_v;
        so_a = so_v;
        if (p > 0) m = m_misr(m, {15'b0, so_v});
        ch = {ch[1:0], si_a};
      end else begin
        checks++;
        if (pi_a !== l[3:0]) begin
          errors++;
          $display("FAIL capture_pi k=%0d: got %h exp %h", k, pi_a, l[3:0]);
        end
        po_v = (mode == 0) ? 1'b0 : 1'($urandom);
        po_a = po_v;
        m = m_misr(m, {15'b0, po_v});
      end
      l = m_lfsr(l);
      @(posedge CK); @(negedge CK);
    end
    if (!hold_start) start_a = 1'b0;
    checks++;
    if ({busy_a, done_a, se_a} !== 3'b010) begin
      errors++;
      $display("FAIL done_cycle: got busy/done/se=%b%b%b exp 010", busy_a, done_a, se_a);
    end
    checks++;
    if ({sig_a, pass_a} !== {m, m == 16'h0000}) begin
      errors++;
      $display("FAIL final_sig_a: got sig=%h pass=%b exp sig=%h pass=%b", sig_a, pass_a, m, m == 16'h0000);
    end
    checks++;
    if ({sig_b, pass_b, done_b} !== {m, m == GOLD_LOOP, 1'b1}) begin
      errors++;
      $display("FAIL final_sig_b: got sig=%h pass=%b done=%b exp sig=%h pass=%b done=1",
               sig_b, pass_b, done_b, m, m == GOLD_LOOP);
    end
    if (mode == 0 && flip_load < 0) begin
      checks++;
      if ({sig_b, pass_b} !== {GOLD_LOOP, 1'b1}) begin
        errors++;
        $display("FAIL golden_pass: got sig=%h pass=%b exp sig=%h pass=1", sig_b, pass_b, GOLD_LOOP);
      end
    end
    @(posedge CK); @(negedge CK);
    if (hold_start) begin
      checks++;
      if ({busy_a, done_a, se_a, si_a} !== {3'b101, SEED_V[0]}) begin
        errors++;
        $display("FAIL rearm: got busy/done/se/si=%b%b%b%b exp 101%b", busy_a, done_a, se_a, si_a, SEED_V[0]);
      end
      start_a = 1'b0;
    end else begin
      checks++;
      if ({busy_a, done_a, sig_a} !== {2'b01, m}) begin
        errors++;
        $display("FAIL done_hold: got busy/done=%b%b sig=%h exp 01 sig=%h", busy_a, done_a, sig_a, m);
      end
    end
  endtask

  task automatic test_reset();
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({se_a, si_a, pi_a, busy_a, done_a, pass_a, sig_a, se_c, busy_c, done_c, sig_c} !== '0) begin
      errors++;
      $display("FAIL reset_values: got se=%b si=%b pi=%h busy=%b done=%b pass=%b sig=%h exp all 0",
               se_a, si_a, pi_a, busy_a, done_a, pass_a, sig_a);
    end
    @(negedge CK); @(negedge CK);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CK); @(negedge CK);
      checks++;
      if ({se_a, busy_a, done_a, sig_a} !== '0) begin
        errors++;
        $display("FAIL idle_quiet i=%0d: got se=%b busy=%b done=%b sig=%h exp 0", i, se_a, busy_a, done_a, sig_a);
      end
    end
  endtask

  task automatic test_default_run();
    run_a(0, -1, -1, 1'b0);
  endtask

  task automatic test_signature_flip();
    repeat (2) @(negedge CK);
    run_a(0, 5, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge CK);
      run_a(1, -1, -1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    run_a(0, -1, (2 * (L + 1)) + L, 1'b0);
    @(negedge CK);
    run_a(0, -1, -1, 1'b0);
  endtask

  task automatic test_start_held();
    @(negedge CK);
    run_a(0, -1, -1, 1'b1);
    #2 RST = 1'b1;
    @(negedge CK);
    RST = 1'b0;
    @(negedge CK);
    checks++;
    if ({busy_a, done_a, se_a} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got busy/done/se=%b%b%b exp 000", busy_a, done_a, se_a);
    end
  endtask

  // Chain of one flop and a single pattern: shift, capture, shift.
  task automatic test_boundary();
    logic [15:0] l;
    logic [15:0] m;
    logic        so_v;
    logic [0:0]  po_v;
    bit          cap;
    for (int r = 0; r < 2; r++) begin
      l = SEED_V;
      m = '0;
      start_c = 1'b1;
      @(posedge CK); @(negedge CK);
      start_c = 1'b0;
      for (int k = 0; k < 3; k++) begin
        cap = (k == 1);
        checks++;
        if ({busy_c, done_c, se_c, sig_c} !== {2'b10, !cap, m}) begin
          errors++;
          $display("FAIL small_run k=%0d: got busy/done/se=%b%b%b sig=%h exp 10%b sig=%h",
                   k, busy_c, done_c, se_c, sig_c, !cap, m);
        end
        checks++;
        if (cap ? (pi_c !== l[3:0]) : (si_c !== l[0])) begin
          errors++;
          $display("FAIL small_stream k=%0d: got si=%b pi=%h exp si=%b pi=%h", k, si_c, pi_c, l[0], l[3:0]);
        end
        if (cap) begin
          po_v = 1'($urandom);
          po_c = po_v;
          m = m_misr(m, {15'b0, po_v});
        end else begin
          so_v = 1'($urandom);
          so_c = so_v;
          if (k == 2) m = m_misr(m, {15'b0, so_v});
        end
        l = m_lfsr(l);
        @(posedge CK); @(negedge CK);
      end
      checks++;
      if ({busy_c, done_c, se_c, sig_c, pass_c} !== {3'b010, m, m == 16'h0000}) begin
        errors++;
        $display("FAIL small_done: got busy/done/se=%b%b%b sig=%h pass=%b exp 010 sig=%h pass=%b",
                 busy_c, done_c, se_c, sig_c, pass_c, m, m == 16'h0000);
      end
      @(negedge CK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_default_run();
    test_signature_flip();
    test_random();
    test_reset_mid();
    test_start_held();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
